// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared core widths, source IDs and helpers for writeback
package writeback_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_IDX_W    = 5;
    localparam int NUM_REGS     = 1 << REG_IDX_W;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2,
        SRC_MDU  = 2'd3
    } src_e;

    // x0 is hardwired, so it never maps to a scoreboard bit
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_IDX_W-1:0] rd,
                                                       input logic                 en);
        rd_onehot = '0;
        if (en && rd != '0) begin
            rd_onehot[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/writeback_arbiter_wb_scoreboard.sv
// rtl/writeback_arbiter_wb_scoreboard.sv - pending-writeback bit per integer register
module wb_scoreboard
    import writeback_arbiter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 set_i,
    input  logic [REG_IDX_W-1:0] set_rd_i,
    input  logic                 clr_i,
    input  logic [REG_IDX_W-1:0] clr_rd_i,
    output logic [NUM_REGS-1:0]  pending_o
);

    // Set is applied after clear so a same-cycle reissue keeps the bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_o <= '0;
        end else begin
            pending_o <= (pending_o & ~rd_onehot(clr_rd_i, clr_i)) | rd_onehot(set_rd_i, set_i);
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - ALU-priority, LSU/MDU round-robin register file write arbiter
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int   XLEN    = XLEN_DEFAULT,
    parameter logic RR_INIT = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alu_valid_i,
    input  logic [REG_IDX_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]      alu_data_i,
    input  logic                 lsu_valid_i,
    input  logic [REG_IDX_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]      lsu_data_i,
    output logic                 lsu_ready_o,
    input  logic                 mdu_valid_i,
    input  logic [REG_IDX_W-1:0] mdu_rd_i,
    input  logic [XLEN-1:0]      mdu_data_i,
    output logic                 mdu_ready_o,
    input  logic                 issue_valid_i,
    input  logic [REG_IDX_W-1:0] issue_rd_i,
    output logic                 reg_write_o,
    output logic [REG_IDX_W-1:0] rd_o,
    output logic [XLEN-1:0]      write_data_o,
    output logic [NUM_REGS-1:0]  pending_o
);

    logic                 rr_q;
    src_e                 grant;
    logic                 accept;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_data;

    // rr_q = 0 prefers the LSU, rr_q = 1 prefers the MDU
    always_comb begin
        grant = SRC_NONE;
        if (alu_valid_i) begin
            grant = SRC_ALU;
        end else if (lsu_valid_i && (!mdu_valid_i || !rr_q)) begin
            grant = SRC_LSU;
        end else if (mdu_valid_i) begin
            grant = SRC_MDU;
        end
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        case (grant)
            SRC_ALU: begin
                sel_rd   = alu_rd_i;
                sel_data = alu_data_i;
            end
            SRC_LSU: begin
                sel_rd   = lsu_rd_i;
                sel_data = lsu_data_i;
            end
            SRC_MDU: begin
                sel_rd   = mdu_rd_i;
                sel_data = mdu_data_i;
            end
            default: begin
                sel_rd   = '0;
                sel_data = '0;
            end
        endcase
    end

    assign accept      = (grant != SRC_NONE);
    assign lsu_ready_o = rst_ni && (grant == SRC_LSU);
    assign mdu_ready_o = rst_ni && (grant == SRC_MDU);

    // rd/data only move on a real write so they hold while reg_write_o is low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_write_o  <= 1'b0;
            rd_o         <= '0;
            write_data_o <= '0;
            rr_q         <= RR_INIT;
        end else begin
            reg_write_o <= accept && (sel_rd != '0);
            if (accept && (sel_rd != '0)) begin
                rd_o         <= sel_rd;
                write_data_o <= sel_data;
            end
            if (grant == SRC_LSU) begin
                rr_q <= 1'b1;
            end else if (grant == SRC_MDU) begin
                rr_q <= 1'b0;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_i    (issue_valid_i),
        .set_rd_i (issue_rd_i),
        .clr_i    (accept),
        .clr_rd_i (sel_rd),
        .pending_o(pending_o)
    );

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter RR_INIT, default 0, initial round-robin pointer (0 = LSU first, 1 = MDU first).
REQ-003 SHALL have clk_i input 1: single clock; all state on its rising edge.
REQ-004 SHALL have rst_ni input 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have alu_valid_i input 1 and alu_rd_i input 5: single-cycle ALU result request and its destination register; no ready, acceptance mandatory.
REQ-006 SHALL have alu_data_i input XLEN: ALU result.
REQ-007 SHALL have lsu_valid_i input 1, lsu_rd_i input 5, lsu_data_i input XLEN and lsu_ready_o output 1: load-unit result handshake.
REQ-008 SHALL have mdu_valid_i input 1, mdu_rd_i input 5, mdu_data_i input XLEN and mdu_ready_o output 1: mul/div result handshake.
REQ-009 SHALL have issue_valid_i input 1 and issue_rd_i input 5: decode marks rd as pending writeback.
REQ-010 SHALL have reg_write_o output 1, rd_o output 5 and write_data_o output XLEN: integer register file write port.
REQ-011 SHALL have pending_o output 32: scoreboard, bit n set while a write to xn is outstanding.

Function
REQ-012 SHALL register the write port: a result accepted in cycle N appears on reg_write_o/rd_o/write_data_o in cycle N+1, for exactly one cycle.
REQ-013 SHALL accept at most one result per cycle.
REQ-014 SHALL grant the ALU unconditionally when alu_valid_i=1; lsu_ready_o and mdu_ready_o SHALL then both be 0.
REQ-015 SHALL, with the ALU idle, grant exactly one of LSU/MDU; if both are valid, the round-robin pointer selects the winner.
REQ-016 SHALL toggle the round-robin pointer only when an LSU/MDU grant occurs, pointing it away from the unit just granted.
REQ-017 SHALL drive lsu_ready_o/mdu_ready_o combinationally; transfer completes when valid and ready are both 1 in the same cycle.
REQ-018 SHALL require sources to hold rd/data stable while valid=1 and ready=0; the arbiter does not buffer unaccepted requests.
REQ-019 SHALL complete the handshake for rd=0 results but keep reg_write_o=0 in the following cycle.
REQ-020 SHALL set pending_o[issue_rd_i] on issue_valid_i=1 with issue_rd_i!=0; bit 0 SHALL always read 0.
REQ-021 SHALL clear pending_o[rd] on the cycle a result for rd is accepted (same edge that loads the output register).
REQ-022 SHALL, when set and clear target the same rd in the same cycle, leave the bit set (set wins).
REQ-023 SHALL keep write_data_o and rd_o at their last values when reg_write_o=0.

Reset
REQ-024 SHALL, on rst_ni=0, asynchronously drive reg_write_o=0, rd_o=0, write_data_o=0, pending_o=0, round-robin pointer=RR_INIT.
REQ-025 SHALL drop a result accepted in the cycle reset asserts; no write issues after reset release for it.
REQ-026 SHALL hold lsu_ready_o=0 and mdu_ready_o=0 while rst_ni=0.

Structure
REQ-027 SHALL take XLEN, register-index width (5) and source-ID encoding (ALU/LSU/MDU) from the shared core package.
REQ-028 SHALL contain one sub-module, wb_scoreboard, holding pending_o with set/clear ports; arbitration and output register stay in the top.

Verification
REQ-029 Bench SHALL cover: ALU rd=5 data=0x0000_00AA in cycle 3 -> reg_write_o=1, rd_o=5, write_data_o=0x0000_00AA in cycle 4 only.
REQ-030 Bench SHALL cover: ALU, LSU(rd=7), MDU(rd=9) valid together for 3 cycles, RR_INIT=0 -> order ALU, then LSU(7), then MDU(9); readies 0 in ALU cycles.
REQ-031 Bench SHALL cover: LSU and MDU both continuously valid, ALU idle, 6 cycles -> grants alternate LSU,MDU,LSU,MDU,LSU,MDU.
REQ-032 Bench SHALL cover: issue rd=12, later MDU result rd=12 -> pending_o[12] 1 from issue edge until accept edge; simultaneous issue rd=12 and accept rd=12 -> bit stays 1.
REQ-033 Bench SHALL cover: LSU result rd=0 data=0xFFFF_FFFF -> lsu_ready_o=1, next cycle reg_write_o=0; issue rd=0 -> pending_o=0.
REQ-034 Bench SHALL cover: rst_ni low mid-cycle with MDU valid and pending_o=0x0000_1000 -> outputs 0 immediately, pointer=RR_INIT, no write after release.
